ex_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline: the consumer of the ID/EX pipeline register bundle. Forwards operands from EX/MEM and MEM/WB, decodes ALU control from ALUop/func, computes the ALU result and write-back register, and registers everything into the EX/MEM pipeline register. Also contains an iterative multiply unit (HI/LO) that stalls the front end on structural or data hazards.

---
 rtl/ex_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_ex_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with operand forwarding, ALU decode and the EX/MEM register.
// Define EX_MDU_EN to build the iterative HI/LO multiply unit and its stall logic.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWritein,
    input  logic        MemWritein,
    input  logic        MemReadin,
    input  logic        ALUsrcin,
    input  logic [1:0]  RegDstin,
    input  logic [1:0]  ALUopin,
    input  logic [1:0]  MemtoRegin,
    input  logic [5:0]  funcin,
    input  logic [4:0]  inst2521in,
    input  logic [4:0]  inst2016in,
    input  logic [4:0]  inst1511in,
    input  logic [31:0] pcp4in,
    input  logic [31:0] rdata1in,
    input  logic [31:0] rdata2in,
    input  logic [31:0] signexin,
    input  logic        exmem_RegWrite,
    input  logic        memwb_RegWrite,
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] exmem_aluout,
    input  logic [31:0] memwb_wdata,
    input  logic        flush,
    output logic        RegWriteout,
    output logic        MemWriteout,
    output logic        MemReadout,
    output logic [1:0]  MemtoRegout,
    output logic [31:0] aluout,
    output logic [31:0] wdataout,
    output logic [31:0] pcp4out,
    output logic [4:0]  rdout,
    output logic        zero,
    output logic        stall
);
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
        OP_MULT, OP_MULTU, OP_MFHI, OP_MFLO
    } alu_op_e;

    alu_op_e     op;
    logic [31:0] fwd_a, fwd_b, alu_b, alu_res;
    logic [4:0]  rd_sel;
    logic        reg_write_d, bubble, stall_w;

    logic        reg_write_q, mem_write_q, mem_read_q, zero_q;
    logic [1:0]  mem_to_reg_q;
    logic [31:0] alu_q, wdata_q, pcp4_q;
    logic [4:0]  rd_q;

`ifdef EX_MDU_EN
    typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_e;
    mdu_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q, mcand_q, acc_d, prod;
    logic [31:0] mplier_q, hi_q, lo_q, a_mag, b_mag;
    logic        neg_q, is_signed, mdu_op, issue;
`endif

    // EX/MEM beats MEM/WB; r0 is never forwarded.
    always_comb begin
        fwd_a = rdata1in;
        if (exmem_RegWrite && exmem_rd != 5'd0 && exmem_rd == inst2521in)
            fwd_a = exmem_aluout;
        else if (memwb_RegWrite && memwb_rd != 5'd0 && memwb_rd == inst2521in)
            fwd_a = memwb_wdata;
    end

    always_comb begin
        fwd_b = rdata2in;
        if (exmem_RegWrite && exmem_rd != 5'd0 && exmem_rd == inst2016in)
            fwd_b = exmem_aluout;
        else if (memwb_RegWrite && memwb_rd != 5'd0 && memwb_rd == inst2016in)
            fwd_b = memwb_wdata;
    end

    assign alu_b = ALUsrcin ? signexin : fwd_b;

    always_comb begin
        op = OP_NOP;
        case (ALUopin)
            2'b00:   op = OP_ADD;
            2'b01:   op = OP_SUB;
            2'b11:   op = OP_SLT;
            default: begin
                case (funcin)
                    FN_ADD:   op = OP_ADD;
                    FN_SUB:   op = OP_SUB;
                    FN_AND:   op = OP_AND;
                    FN_OR:    op = OP_OR;
                    FN_SLT:   op = OP_SLT;
`ifdef EX_MDU_EN
                    FN_MULT:  op = OP_MULT;
                    FN_MULTU: op = OP_MULTU;
                    FN_MFHI:  op = OP_MFHI;
                    FN_MFLO:  op = OP_MFLO;
`endif
                    default:  op = OP_NOP;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_res = 32'd0;
        case (op)
            OP_ADD:  alu_res = fwd_a + alu_b;
            OP_SUB:  alu_res = fwd_a - alu_b;
            OP_AND:  alu_res = fwd_a & alu_b;
            OP_OR:   alu_res = fwd_a | alu_b;
            OP_SLT:  alu_res = {31'd0, $signed(fwd_a) < $signed(alu_b)};
`ifdef EX_MDU_EN
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
`endif
            default: alu_res = 32'd0;
        endcase
    end

    always_comb begin
        case (RegDstin)
            2'b00:   rd_sel = inst2016in;
            2'b01:   rd_sel = inst1511in;
            2'b10:   rd_sel = 5'd31;
            default: rd_sel = 5'd0;
        endcase
    end

    // Multiplies write only HI/LO, never the register file.
    assign reg_write_d = RegWritein && !(op inside {OP_NOP, OP_MULT, OP_MULTU});

`ifdef EX_MDU_EN
    assign mdu_op    = op inside {OP_MULT, OP_MULTU, OP_MFHI, OP_MFLO};
    assign stall_w   = (state_q == MDU_BUSY) && mdu_op;
    assign is_signed = (op == OP_MULT);
    assign issue     = (state_q == MDU_IDLE) && (op inside {OP_MULT, OP_MULTU}) && !flush;
    assign a_mag     = (is_signed && fwd_a[31]) ? -fwd_a : fwd_a;
    assign b_mag     = (is_signed && fwd_b[31]) ? -fwd_b : fwd_b;
    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    assign prod      = neg_q ? -acc_d : acc_d;

    // Unsigned shift-add on magnitudes; sign is reapplied on the final step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            neg_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (issue) begin
                        state_q  <= MDU_BUSY;
                        cnt_q    <= 5'd0;
                        acc_q    <= 64'd0;
                        mcand_q  <= {32'd0, a_mag};
                        mplier_q <= b_mag;
                        neg_q    <= is_signed && (fwd_a[31] ^ fwd_b[31]);
                    end
                end
                MDU_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q      <= MDU_IDLE;
                        {hi_q, lo_q} <= prod;
                    end
                end
                default: state_q <= MDU_IDLE;
            endcase
        end
    end
`else
    assign stall_w = 1'b0;
`endif

    assign bubble = flush || stall_w;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_to_reg_q <= 2'd0;
            alu_q        <= 32'd0;
            wdata_q      <= 32'd0;
            pcp4_q       <= 32'd0;
            rd_q         <= 5'd0;
            zero_q       <= 1'b0;
        end else begin
            reg_write_q  <= !bubble && reg_write_d;
            mem_write_q  <= !bubble && MemWritein;
            mem_read_q   <= !bubble && MemReadin;
            mem_to_reg_q <= bubble ? 2'd0 : MemtoRegin;
            alu_q        <= alu_res;
            wdata_q      <= fwd_b;
            pcp4_q       <= pcp4in;
            rd_q         <= rd_sel;
            zero_q       <= (alu_res == 32'd0);
        end
    end

    assign RegWriteout = reg_write_q;
    assign MemWriteout = mem_write_q;
    assign MemReadout  = mem_read_q;
    assign MemtoRegout = mem_to_reg_q;
    assign aluout      = alu_q;
    assign wdataout    = wdata_q;
    assign pcp4out     = pcp4_q;
    assign rdout       = rd_q;
    assign zero        = zero_q;
    assign stall       = stall_w;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized scoreboard bench for ex_stage; reference model tracks HI/LO and multiply
// busy time by cycle count and follows the EX_MDU_EN build option.
module tb_ex_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        RegWritein, MemWritein, MemReadin, ALUsrcin;
    logic [1:0]  RegDstin, ALUopin, MemtoRegin;
    logic [5:0]  funcin;
    logic [4:0]  inst2521in, inst2016in, inst1511in;
    logic [31:0] pcp4in, rdata1in, rdata2in, signexin;
    logic        exmem_RegWrite, memwb_RegWrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_aluout, memwb_wdata;
    logic        flush;
    logic        RegWriteout, MemWriteout, MemReadout;
    logic [1:0]  MemtoRegout;
    logic [31:0] aluout, wdataout, pcp4out;
    logic [4:0]  rdout;
    logic        zero, stall;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .RegWritein(RegWritein), .MemWritein(MemWritein), .MemReadin(MemReadin),
        .ALUsrcin(ALUsrcin), .RegDstin(RegDstin), .ALUopin(ALUopin),
        .MemtoRegin(MemtoRegin), .funcin(funcin),
        .inst2521in(inst2521in), .inst2016in(inst2016in), .inst1511in(inst1511in),
        .pcp4in(pcp4in), .rdata1in(rdata1in), .rdata2in(rdata2in), .signexin(signexin),
        .exmem_RegWrite(exmem_RegWrite), .memwb_RegWrite(memwb_RegWrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_aluout(exmem_aluout), .memwb_wdata(memwb_wdata), .flush(flush),
        .RegWriteout(RegWriteout), .MemWriteout(MemWriteout), .MemReadout(MemReadout),
        .MemtoRegout(MemtoRegout), .aluout(aluout), .wdataout(wdataout),
        .pcp4out(pcp4out), .rdout(rdout), .zero(zero), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        regwrite, memwrite, memread, alusrc, flush;
        logic [1:0]  regdst, aluop, memtoreg;
        logic [5:0]  func;
        logic [4:0]  rs, rt, rd, exrd, mwrd;
        logic [31:0] pcp4, rdata1, rdata2, signex, exval, mwval;
        logic        exw, mww;
    } stim_t;

    typedef struct {
        logic        chk_data, chk_alu;
        logic        rw, mw, mr, zero;
        logic [1:0]  m2r;
        logic [31:0] alu, wdata, pcp4;
        logic [4:0]  rd;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0, n_fail = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [63:0] m_pending = 64'd0;
    int          busy_left = 0;
    logic [5:0]  fn_tab [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h18,
                                 6'h19, 6'h10, 6'h12, 6'h00, 6'h3f, 6'h21};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] fwdv(input logic [4:0] src, input logic [31:0] rf, input stim_t s);
        if (s.exw && s.exrd == src && src != 5'd0) return s.exval;
        if (s.mww && s.mwrd == src && src != 5'd0) return s.mwval;
        return rf;
    endfunction

    function automatic void model(input stim_t s, output exp_t e, output bit ms,
                                  output bit iss, output logic [63:0] pr);
        logic [31:0] a, b, bv, res;
        logic signed [63:0] sa, sb;
        bit wr, known, mdu, bub;
        a = fwdv(s.rs, s.rdata1, s);
        b = fwdv(s.rt, s.rdata2, s);
        bv = s.alusrc ? s.signex : b;
        wr = s.regwrite; known = 1; mdu = 0; iss = 0; pr = 64'd0; res = 32'd0;
        case (s.aluop)
            2'd0: res = a + bv;
            2'd1: res = a - bv;
            2'd3: res = ($signed(a) < $signed(bv)) ? 32'd1 : 32'd0;
            default: begin
                case (s.func)
                    6'h20: res = a + bv;
                    6'h22: res = a - bv;
                    6'h24: res = a & bv;
                    6'h25: res = a | bv;
                    6'h2a: res = ($signed(a) < $signed(bv)) ? 32'd1 : 32'd0;
`ifdef EX_MDU_EN
                    6'h18, 6'h19: begin
                        wr = 0; known = 0; mdu = 1;
                        iss = (busy_left == 0) && !s.flush;
                        if (s.func == 6'h18) begin
                            sa = $signed(a); sb = $signed(b); pr = sa * sb;
                        end else pr = {32'd0, a} * {32'd0, b};
                    end
                    6'h10: begin res = m_hi; mdu = 1; end
                    6'h12: begin res = m_lo; mdu = 1; end
`endif
                    default: begin wr = 0; known = 0; end
                endcase
            end
        endcase
        ms  = mdu && (busy_left > 0);
        bub = s.flush || ms;
        e.chk_data = !bub;
        e.chk_alu  = !bub && known;
        e.rw   = !bub && wr;
        e.mw   = !bub && s.memwrite;
        e.mr   = !bub && s.memread;
        e.m2r  = bub ? 2'd0 : s.memtoreg;
        e.alu  = res;
        e.zero = (res == 32'd0);
        e.wdata = b;
        e.pcp4 = s.pcp4;
        case (s.regdst)
            2'd0: e.rd = s.rt;
            2'd1: e.rd = s.rd;
            2'd2: e.rd = 5'd31;
            default: e.rd = 5'd0;
        endcase
    endfunction

    task automatic apply(input stim_t s);
        RegWritein = s.regwrite; MemWritein = s.memwrite; MemReadin = s.memread;
        ALUsrcin = s.alusrc; RegDstin = s.regdst; ALUopin = s.aluop; MemtoRegin = s.memtoreg;
        funcin = s.func; inst2521in = s.rs; inst2016in = s.rt; inst1511in = s.rd;
        pcp4in = s.pcp4; rdata1in = s.rdata1; rdata2in = s.rdata2; signexin = s.signex;
        exmem_RegWrite = s.exw; memwb_RegWrite = s.mww; exmem_rd = s.exrd; memwb_rd = s.mwrd;
        exmem_aluout = s.exval; memwb_wdata = s.mwval; flush = s.flush;
    endtask

    task automatic drive(input stim_t s, output bit ms, output bit ds);
        exp_t e; bit iss; logic [63:0] pr;
        @(negedge clk);
        apply(s);
        #1;
        model(s, e, ms, iss, pr);
        ds = stall;
        chk("stall", 64'(stall), 64'(ms));
        q.push_back(e);
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) {m_hi, m_lo} = m_pending;
        end else if (iss) begin
            busy_left = 32;
            m_pending = pr;
        end
    endtask

    // Front end holds the instruction in ID/EX while stalled.
    task automatic issue(input stim_t s, output int nst);
        int n; bit ms, ds;
        n = 0; nst = 0;
        do begin
            drive(s, ms, ds);
            if (ds) nst++;
            n++;
        end while (ms && n < 100);
        if (n >= 100) chk("stall_timeout", 64'(n), 64'd0);
    endtask

    function automatic stim_t base();
        stim_t s;
        s = '{default: '0};
        s.pcp4 = $urandom; s.signex = $urandom;
        return s;
    endfunction

    function automatic stim_t rtype(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2);
        stim_t s;
        s = base();
        s.regwrite = 1; s.regdst = 2'b01; s.aluop = 2'b10; s.func = fn;
        s.rs = rs; s.rt = rt; s.rd = rd; s.rdata1 = r1; s.rdata2 = r2;
        return s;
    endfunction

    task automatic async_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_ctl", 64'({RegWriteout, MemWriteout, MemReadout, MemtoRegout, rdout, zero, stall}), 64'd0);
        chk("rst_data", {aluout, wdataout}, 64'd0);
        chk("rst_pcp4", 64'(pcp4out), 64'd0);
        q.delete();
        m_hi = 32'd0; m_lo = 32'd0; busy_left = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("RegWriteout", 64'(RegWriteout), 64'(e.rw));
                chk("MemWriteout", 64'(MemWriteout), 64'(e.mw));
                chk("MemReadout", 64'(MemReadout), 64'(e.mr));
                chk("MemtoRegout", 64'(MemtoRegout), 64'(e.m2r));
                if (e.chk_data) begin
                    chk("wdataout", 64'(wdataout), 64'(e.wdata));
                    chk("pcp4out", 64'(pcp4out), 64'(e.pcp4));
                    chk("rdout", 64'(rdout), 64'(e.rd));
                end
                if (e.chk_alu) begin
                    chk("aluout", 64'(aluout), 64'(e.alu));
                    chk("zero", 64'(zero), 64'(e.zero));
                end
            end
        end
    end

    initial begin : stim
        stim_t s;
        int nst;
        apply(base());
        #1 rst = 1'b0;
        #11;
        chk("init_ctl", 64'({RegWriteout, MemWriteout, MemReadout, MemtoRegout, rdout, zero, stall}), 64'd0);
        chk("init_data", {aluout, wdataout}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // add $3,$1,$2
        s = rtype(6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        issue(s, nst);
        @(posedge clk); #2;
        chk("add_alu", 64'(aluout), 64'd12);
        chk("add_rd", 64'(rdout), 64'd3);
        chk("add_rw_zero", 64'({RegWriteout, zero}), 64'b10);

        async_reset();

        // Forwarding priority and r0 exclusion
        s = rtype(6'h20, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7);
        s.exw = 1; s.exrd = 5'd1; s.exval = 32'd100;
        s.mww = 1; s.mwrd = 5'd1; s.mwval = 32'd200;
        issue(s, nst);
        @(posedge clk); #2;
        chk("fwd_exmem", 64'(aluout), 64'd107);
        s.exrd = 5'd3;
        issue(s, nst);
        @(posedge clk); #2;
        chk("fwd_memwb", 64'(aluout), 64'd207);
        s.rs = 5'd0; s.exrd = 5'd0; s.mwrd = 5'd0;
        issue(s, nst);
        @(posedge clk); #2;
        chk("fwd_r0", 64'(aluout), 64'd12);

        // sub of equal operands sets zero
        s = rtype(6'h22, 5'd1, 5'd2, 5'd5, 32'd9, 32'd9);
        issue(s, nst);
        @(posedge clk); #2;
        chk("sub_zero", 64'(zero), 64'd1);

        // mult -3 x 4, then dependent mfhi / mflo
        issue(rtype(6'h18, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFD, 32'd4), nst);
        issue(rtype(6'h10, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0), nst);
        @(posedge clk); #2;
`ifdef EX_MDU_EN
        chk("mfhi_stall_cycles", 64'(nst), 64'd32);
        chk("mult_hi", 64'(aluout), 64'hFFFF_FFFF);
        chk("mfhi_rw", 64'(RegWriteout), 64'd1);
`else
        chk("mfhi_stall_cycles", 64'(nst), 64'd0);
        chk("mfhi_nop_rw", 64'(RegWriteout), 64'd0);
`endif
        issue(rtype(6'h12, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0), nst);
        @(posedge clk); #2;
`ifdef EX_MDU_EN
        chk("mult_lo", 64'(aluout), 64'hFFFF_FFF4);
`endif

        // multu 0xFFFFFFFF x 2
        issue(rtype(6'h19, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'd2), nst);
        issue(rtype(6'h10, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0), nst);
        @(posedge clk); #2;
`ifdef EX_MDU_EN
        chk("multu_hi", 64'(aluout), 64'd1);
`endif
        issue(rtype(6'h12, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0), nst);
        @(posedge clk); #2;
`ifdef EX_MDU_EN
        chk("multu_lo", 64'(aluout), 64'hFFFF_FFFE);
`endif

        // flushed mult never starts; HI keeps the multu result
        s = rtype(6'h18, 5'd1, 5'd2, 5'd0, 32'd7, 32'd9);
        s.flush = 1;
        issue(s, nst);
        issue(rtype(6'h10, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0), nst);
        chk("flush_mult_no_stall", 64'(nst), 64'd0);
        @(posedge clk); #2;
`ifdef EX_MDU_EN
        chk("flush_hi_kept", 64'(aluout), 64'd1);
`endif

        // flushed add is a bubble
        s = rtype(6'h20, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2);
        s.memread = 1; s.memwrite = 1; s.memtoreg = 2'd1; s.flush = 1;
        issue(s, nst);
        @(posedge clk); #2;
        chk("flush_add_ctl", 64'({RegWriteout, MemWriteout, MemReadout, MemtoRegout}), 64'd0);

        // reset mid-multiply clears HI/LO
        issue(rtype(6'h18, 5'd1, 5'd2, 5'd0, 32'd7, 32'd9), nst);
        for (int i = 0; i < 3; i++) issue(rtype(6'h25, 5'd1, 5'd2, 5'd3, 32'd3, 32'd4), nst);
        async_reset();
        issue(rtype(6'h10, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0), nst);
        chk("rst_mdu_no_stall", 64'(nst), 64'd0);
        @(posedge clk); #2;
`ifdef EX_MDU_EN
        chk("rst_hi_zero", 64'(aluout), 64'd0);
`endif

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            s = base();
            s.regwrite = 1'($urandom); s.memwrite = 1'($urandom); s.memread = 1'($urandom);
            s.alusrc = ($urandom_range(0, 3) == 0);
            s.regdst = 2'($urandom); s.aluop = 2'($urandom); s.memtoreg = 2'($urandom);
            if ($urandom_range(0, 1) == 1) s.aluop = 2'b10;
            s.func = fn_tab[$urandom_range(0, 11)];
            s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
            s.rd = 5'($urandom);
            s.rdata1 = $urandom; s.rdata2 = $urandom;
            if ($urandom_range(0, 3) == 0) s.rdata2 = s.rdata1;
            s.exw = 1'($urandom); s.mww = 1'($urandom);
            s.exrd = 5'($urandom_range(0, 3)); s.mwrd = 5'($urandom_range(0, 3));
            s.exval = $urandom; s.mwval = $urandom;
            s.flush = ($urandom_range(0, 9) == 0);
            issue(s, nst);
        end

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) chk("scoreboard_drain", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
